ipsmacge_txpktfifo: RTL and testbench



---
 rtl/ipsmacge_pkg.sv | 11 +
 rtl/ipsmacge_txpktfifo_mem.sv | 29 ++
 rtl/ipsmacge_txpktfifo.sv | 131 +++++++++++++
 tb/tb_ipsmacge_txpktfifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsmacge_pkg.sv
// Shared constants for the GE MAC TX packet FIFO: entry layout and statistics counter width.
package ipsmacge_pkg;

   localparam int STAT_W = 16;

   // Each stored entry is {eop, data}; the EOP tag sits just above the data word.
   function automatic int eop_bit(input int width);
      return width;
   endfunction

endpackage

// File: rtl/ipsmacge_txpktfifo_mem.sv
// Register array for the TX packet FIFO: synchronous write, asynchronous (show-ahead) read.
module ipsmacge_txpktfifo_mem #(
   parameter int ADDRBIT = 4,
   parameter int WIDTH   = 8
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               we,
   input  logic [ADDRBIT-1:0] waddr,
   input  logic [WIDTH:0]     wdata,
   input  logic [ADDRBIT-1:0] raddr,
   output logic [WIDTH:0]     rdata
);

   localparam int DEPTH = 1 << ADDRBIT;

   logic [WIDTH:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ipsmacge_txpktfifo.sv
// Packet-aware TX FIFO with store-and-forward commit/abort, flags, packet count and flush.
// Optional dropped-write statistics counter built when IPSMACGE_TXFIFO_STAT_EN is defined.
module ipsmacge_txpktfifo
   import ipsmacge_pkg::*;
#(
   parameter int ADDRBIT  = 4,
   parameter int LENGTH   = 16,
   parameter int WIDTH    = 8,
   parameter int AFULL_TH = 12,
   parameter int SAF      = 1
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               flush,
   input  logic               fifowr,
   input  logic [WIDTH-1:0]   fifodin,
   input  logic               fifoeop,
   input  logic               fifoabort,
   input  logic               fiford,
   output logic [WIDTH-1:0]   fifodout,
   output logic               fifodouteop,
   output logic               fifofull,
   output logic               fifoafull,
   output logic               notempty,
   output logic [ADDRBIT:0]   fifolen,
   output logic [ADDRBIT:0]   pktcnt,
   output logic               ovflow,
   input  logic               clrovf,
   output logic [STAT_W-1:0]  wrdropcnt
);

   localparam int               EOPB    = eop_bit(WIDTH);
   localparam logic [ADDRBIT:0] LEN_MAX = (ADDRBIT+1)'(LENGTH);
   localparam logic [ADDRBIT:0] AF_TH   = (ADDRBIT+1)'(AFULL_TH);
   localparam logic             SAF_EN  = (SAF != 0);

   logic [ADDRBIT-1:0] wrcnt, wrsop, rdcnt;
   logic [ADDRBIT:0]   cmtlen;
   logic [WIDTH:0]     wr_entry, rd_entry;
   logic               abort_eff, write, read, wr_drop, wr_eop, rd_eop, cmt_dec;
   logic [ADDRBIT:0]   wr_inc, rd_dec, cmt_sub, pkt_inc, pkt_dec;

   assign abort_eff = fifoabort & SAF_EN;
   assign fifofull  = (fifolen == LEN_MAX);
   assign fifoafull = (fifolen >= AF_TH);
   assign notempty  = SAF_EN ? (cmtlen != '0) : (fifolen != '0);

   assign write   = fifowr & ~fifofull & ~abort_eff & ~flush;
   assign read    = fiford & notempty & ~flush;
   assign wr_drop = fifowr & fifofull & ~abort_eff;
   assign wr_eop  = write & fifoeop;
   assign rd_eop  = read & rd_entry[EOPB];
   // In cut-through mode cmtlen may lag reads of uncommitted data, so it never underflows.
   assign cmt_dec = read & (cmtlen != '0);

   assign wr_inc  = (ADDRBIT+1)'(write);
   assign rd_dec  = (ADDRBIT+1)'(read);
   assign cmt_sub = (ADDRBIT+1)'(cmt_dec);
   assign pkt_inc = (ADDRBIT+1)'(wr_eop);
   assign pkt_dec = (ADDRBIT+1)'(rd_eop);

   assign wr_entry    = {fifoeop, fifodin};
   assign fifodout    = rd_entry[WIDTH-1:0];
   assign fifodouteop = rd_entry[EOPB];

   ipsmacge_txpktfifo_mem #(
      .ADDRBIT (ADDRBIT),
      .WIDTH   (WIDTH)
   ) u_mem (
      .clk   (clk),
      .rst_  (rst_),
      .we    (write),
      .waddr (wrcnt),
      .wdata (wr_entry),
      .raddr (rdcnt),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wrcnt   <= '0;
         wrsop   <= '0;
         rdcnt   <= '0;
         fifolen <= '0;
         cmtlen  <= '0;
         pktcnt  <= '0;
      end else if (flush) begin
         wrcnt   <= '0;
         wrsop   <= '0;
         rdcnt   <= '0;
         fifolen <= '0;
         cmtlen  <= '0;
         pktcnt  <= '0;
      end else begin
         if (read) rdcnt <= rdcnt + ADDRBIT'(1);
         if (abort_eff) begin
            // Rewind to the start of the open packet; only committed entries survive.
            wrcnt   <= wrsop;
            fifolen <= cmtlen - rd_dec;
            cmtlen  <= cmtlen - cmt_sub;
         end else begin
            if (write) wrcnt <= wrcnt + ADDRBIT'(1);
            if (wr_eop) begin
               wrsop  <= wrcnt + ADDRBIT'(1);
               cmtlen <= fifolen + wr_inc - rd_dec;
            end else begin
               cmtlen <= cmtlen - cmt_sub;
            end
            fifolen <= fifolen + wr_inc - rd_dec;
         end
         pktcnt <= pktcnt + pkt_inc - pkt_dec;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)        ovflow <= 1'b0;
      else if (wr_drop) ovflow <= 1'b1;
      else if (clrovf)  ovflow <= 1'b0;
   end

`ifdef IPSMACGE_TXFIFO_STAT_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)                            wrdropcnt <= '0;
      else if (clrovf)                      wrdropcnt <= STAT_W'(wr_drop);
      else if (wr_drop && wrdropcnt != '1)  wrdropcnt <= wrdropcnt + STAT_W'(1);
   end
`else
   assign wrdropcnt = '0;
`endif

endmodule

// File: tb/tb_ipsmacge_txpktfifo.sv
// Scoreboard bench for ipsmacge_txpktfifo: one store-and-forward and one cut-through instance.
module tb_ipsmacge_txpktfifo;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       flush = 1'b0, fifowr = 1'b0, fifoeop = 1'b0, fifoabort = 1'b0;
   logic       fiford = 1'b0, clrovf = 1'b0;
   logic [7:0] fifodin = 8'h00;

   logic [7:0]  dout0, dout1;
   logic        deop0, deop1, full0, full1, afull0, afull1, ne0, ne1, ovf0, ovf1;
   logic [4:0]  len0, len1, pkt0, pkt1;
   logic [15:0] drops0, drops1;

`ifdef IPSMACGE_TXFIFO_STAT_EN
   localparam int EXP_DROP1 = 1;
`else
   localparam int EXP_DROP1 = 0;
`endif

   always #5 clk = ~clk;

   ipsmacge_txpktfifo #(.SAF(1)) u_saf (
      .clk(clk), .rst_(rst_), .flush(flush), .fifowr(fifowr), .fifodin(fifodin),
      .fifoeop(fifoeop), .fifoabort(fifoabort), .fiford(fiford), .fifodout(dout0),
      .fifodouteop(deop0), .fifofull(full0), .fifoafull(afull0), .notempty(ne0),
      .fifolen(len0), .pktcnt(pkt0), .ovflow(ovf0), .clrovf(clrovf), .wrdropcnt(drops0)
   );

   ipsmacge_txpktfifo #(.SAF(0)) u_ct (
      .clk(clk), .rst_(rst_), .flush(flush), .fifowr(fifowr), .fifodin(fifodin),
      .fifoeop(fifoeop), .fifoabort(fifoabort), .fiford(fiford), .fifodout(dout1),
      .fifodouteop(deop1), .fifofull(full1), .fifoafull(afull1), .notempty(ne1),
      .fifolen(len1), .pktcnt(pkt1), .ovflow(ovf1), .clrovf(clrovf), .wrdropcnt(drops1)
   );

   int n_vec = 0, n_err = 0;

   // Reference model: index 0 = store-and-forward, 1 = cut-through.
   logic [8:0] mq   [2][$];
   logic [8:0] expq [2][$];
   int         ncmt [2];
   logic       ovf_m[2];
   int         drops_m[2];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         expq[k].delete();
         ncmt[k]    = 0;
         ovf_m[k]   = 1'b0;
         drops_m[k] = 0;
      end
   endtask

   task automatic check_dut(input int k);
      logic [7:0]  d;
      logic        de, fu, af, ne, ov;
      logic [4:0]  l, p;
      logic [15:0] dc;
      int          sz, pk;
      if (k == 0) begin
         d = dout0; de = deop0; fu = full0; af = afull0; ne = ne0; ov = ovf0;
         l = len0; p = pkt0; dc = drops0;
      end else begin
         d = dout1; de = deop1; fu = full1; af = afull1; ne = ne1; ov = ovf1;
         l = len1; p = pkt1; dc = drops1;
      end
      sz = mq[k].size();
      pk = 0;
      for (int i = 0; i < sz; i++) pk += int'(mq[k][i][8]);
      chk("fifolen",   k, 32'(l),  32'(sz));
      chk("pktcnt",    k, 32'(p),  32'(pk));
      chk("notempty",  k, 32'(ne), 32'((k == 0) ? (ncmt[k] != 0) : (sz != 0)));
      chk("fifofull",  k, 32'(fu), 32'(sz == 16));
      chk("fifoafull", k, 32'(af), 32'(sz >= 12));
      chk("ovflow",    k, 32'(ov), 32'(ovf_m[k]));
      chk("wrdropcnt", k, 32'(dc), 32'(drops_m[k]));
      if (sz > 0) chk("head", k, {23'b0, de, d}, {23'b0, mq[k][0]});
   endtask

   task automatic model_step(input int k, input logic wr, input logic [7:0] din, input logic eop,
                             input logic ab, input logic rd, input logic fl, input logic co);
      bit saf  = (k == 0);
      int sz   = mq[k].size();
      bit full = (sz == 16);
      bit ne   = saf ? (ncmt[k] != 0) : (sz != 0);
      bit ab_e = ab && saf;
      bit rdo  = rd && ne && !fl;
      bit wro  = wr && !full && !ab_e && !fl;
      bit drp  = wr && full && !ab_e;
      if (rdo) expq[k].push_back(mq[k][0]);
      if (fl) begin
         mq[k].delete();
         ncmt[k] = 0;
      end else begin
         if (rdo) begin
            void'(mq[k].pop_front());
            if (ncmt[k] > 0) ncmt[k]--;
         end
         if (ab_e) begin
            while (mq[k].size() > ncmt[k]) void'(mq[k].pop_back());
         end else if (wro) begin
            mq[k].push_back({eop, din});
            if (eop) ncmt[k] = mq[k].size();
         end
      end
      if (drp)     ovf_m[k] = 1'b1;
      else if (co) ovf_m[k] = 1'b0;
`ifdef IPSMACGE_TXFIFO_STAT_EN
      if (co)                              drops_m[k] = drp ? 1 : 0;
      else if (drp && drops_m[k] < 65535) drops_m[k]++;
`endif
   endtask

   // One clock: check the state left by the previous edge, then drive and predict the next one.
   task automatic cycle(input logic wr, input logic eop, input logic ab, input logic rd,
                        input logic fl, input logic co);
      logic [7:0] din;
      @(posedge clk); #1;
      check_dut(0);
      check_dut(1);
      din       = 8'($urandom_range(0, 255));
      fifowr    = wr;   fifodin = din; fifoeop = eop; fifoabort = ab;
      fiford    = rd;   flush   = fl;  clrovf  = co;
      model_step(0, wr, din, eop, ab, rd, fl, co);
      model_step(1, wr, din, eop, ab, rd, fl, co);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mon(input int k, input logic [8:0] act);
      logic [8:0] e;
      if (expq[k].size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL rd_unexpected dut%0d: got %0h expected no read", k, act);
      end else begin
         e = expq[k].pop_front();
         chk("rd_data", k, {23'b0, act}, {23'b0, e});
      end
   endtask

   always @(negedge clk) begin
      if (rst_ && fiford && !flush && ne0) mon(0, {deop0, dout0});
      if (rst_ && fiford && !flush && ne1) mon(1, {deop1, dout1});
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_dout", 0, {23'b0, deop0, dout0}, 32'h0);
      rst_ = 1'b1;

      // Packet of 3, committed on the third word, then drained.
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0);
      idle();
      chk("t1_pktcnt", 0, 32'(pkt0), 32'd1);
      chk("t1_len",    0, 32'(len0), 32'd3);
      repeat (3) cycle(0, 0, 0, 1, 0, 0);
      idle();
      chk("t1_drained", 0, 32'(len0), 32'd0);

      // Abort an open packet; next packet lands at the rewound pointer.
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      idle();
      chk("t2_len",    0, 32'(len0), 32'd0);
      chk("t2_pktcnt", 0, 32'(pkt0), 32'd0);
      chk("t2_ct_len", 1, 32'(len1), 32'd2);
      cycle(1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 1, 0);
      idle();
      chk("t2_flush", 1, 32'(len1), 32'd0);

      // Fill to full, then an overflowing write.
      for (int i = 0; i < 16; i++) cycle(1, (i == 15), 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      idle();
      chk("t3_full",  0, 32'(full0),  32'd1);
      chk("t3_afull", 0, 32'(afull0), 32'd1);
      chk("t3_ovf",   0, 32'(ovf0),   32'd1);
      chk("t3_drops", 0, 32'(drops0), 32'(EXP_DROP1));

      // Simultaneous read and EOP write: non-EOP head, then EOP head.
      repeat (11) cycle(0, 0, 0, 1, 0, 0);
      cycle(1, 1, 0, 1, 0, 0);
      idle();
      chk("t4_len_a", 0, 32'(len0), 32'd5);
      chk("t4_pkt_a", 0, 32'(pkt0), 32'd2);
      repeat (3) cycle(0, 0, 0, 1, 0, 0);
      cycle(1, 1, 0, 1, 0, 0);
      idle();
      chk("t4_len_b", 0, 32'(len0), 32'd2);
      chk("t4_pkt_b", 0, 32'(pkt0), 32'd2);

      // Flush with 9 entries / 2 packets and a concurrent write.
      cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cycle(1, (i == 3), 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, (i == 4), 0, 0, 0, 0);
      idle();
      chk("t5_len_pre", 0, 32'(len0), 32'd9);
      chk("t5_pkt_pre", 0, 32'(pkt0), 32'd2);
      cycle(1, 0, 0, 0, 1, 0);
      idle();
      chk("t5_len",  0, 32'(len0), 32'd0);
      chk("t5_pkt",  0, 32'(pkt0), 32'd0);
      chk("t5_ovf",  0, 32'(ovf0), 32'd1);
      cycle(0, 0, 0, 0, 0, 1);
      idle();
      chk("t3_clrovf",   0, 32'(ovf0),   32'd0);
      chk("t3_clrdrops", 0, 32'(drops0), 32'd0);

      // Cut-through exposes an unterminated word; abort is ignored there.
      cycle(1, 0, 0, 0, 0, 0);
      idle();
      chk("t6_ct_ne",  1, 32'(ne1), 32'd1);
      chk("t6_saf_ne", 0, 32'(ne0), 32'd0);
      cycle(0, 0, 1, 0, 0, 0);
      idle();
      chk("t6_ct_len", 1, 32'(len1), 32'd1);

      // Asynchronous reset in the middle of a packet.
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      rst_ = 1'b0;
      fifowr = 1'b0; fifoeop = 1'b0; fifoabort = 1'b0; fiford = 1'b0; flush = 1'b0; clrovf = 1'b0;
      #1;
      chk("t7_len",  0, 32'(len0), 32'd0);
      chk("t7_len",  1, 32'(len1), 32'd0);
      chk("t7_pkt",  1, 32'(pkt1), 32'd0);
      chk("t7_ne",   1, 32'(ne1),  32'd0);
      chk("t7_ovf",  0, 32'(ovf0), 32'd0);
      chk("t7_dout", 1, {23'b0, deop1, dout1}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_ = 1'b1;

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 4),  ($urandom_range(0, 99) < ((n / 500) % 2 ? 70 : 40)),
               ($urandom_range(0, 199) < 3), ($urandom_range(0, 99) < 5));
      end
      idle();
      idle();
      chk("sb_drain", 0, 32'(expq[0].size()), 32'd0);
      chk("sb_drain", 1, 32'(expq[1].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
